// File: rtl/gs_dac_pkg.sv
// Shared definitions for the multi-channel General Sound DAC.
//   dac_mode_e : per-channel output mode (sigma-delta or PWM)
//   ch_width() : width of a channel index, never narrower than one bit
package gs_dac_pkg;

  typedef enum logic {
    MODE_SD  = 1'b0,
    MODE_PWM = 1'b1
  } dac_mode_e;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gs_dac_multi_if.sv
// Bus-side interface of gs_dac_multi.
//   smp_wr/smp_ch/smp_data : sample write strobe, channel index, value
//   vol_wr/vol_ch/vol_data : volume write strobe, channel index, value
//   mode                   : per channel, 0 = sigma-delta, 1 = PWM
//   mute                   : global mute
//   dac_out                : registered 1-bit DAC outputs
//   frame_tick             : one-cycle pulse on each commit cycle
// master = bus decoder side, slave = DAC side.
interface gs_dac_multi_if #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 8,
  parameter int VOL_W    = 6
);
  localparam int CH_W = gs_dac_pkg::ch_width(CHANNELS);

  logic                smp_wr;
  logic [CH_W-1:0]     smp_ch;
  logic [DATA_W-1:0]   smp_data;
  logic                vol_wr;
  logic [CH_W-1:0]     vol_ch;
  logic [VOL_W-1:0]    vol_data;
  logic [CHANNELS-1:0] mode;
  logic                mute;
  logic [CHANNELS-1:0] dac_out;
  logic                frame_tick;

  modport master (
    output smp_wr, smp_ch, smp_data, vol_wr, vol_ch, vol_data, mode, mute,
    input  dac_out, frame_tick
  );

  modport slave (
    input  smp_wr, smp_ch, smp_data, vol_wr, vol_ch, vol_data, mode, mute,
    output dac_out, frame_tick
  );
endinterface

// File: rtl/gs_dac_channel.sv
// One DAC channel: double-buffered sample, sigma-delta accumulator,
// PWM counter and the registered output bit.
//   clk32, rst   : clock, synchronous active-high reset
//   i_smp_wr     : sample write for this channel (already decoded)
//   i_smp_data   : sample value as written on the bus
//   i_vol_en     : volume gate for this cycle
//   i_commit     : frame boundary, pending sample becomes active
//   i_mode       : 0 = sigma-delta, 1 = PWM
//   i_mute       : force output low, hold accumulator/counter at 0
//   o_dac        : registered 1-bit output
module gs_dac_channel
  import gs_dac_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int SIGNED_IN = 0
) (
  input  logic              clk32,
  input  logic              rst,
  input  logic              i_smp_wr,
  input  logic [DATA_W-1:0] i_smp_data,
  input  logic              i_vol_en,
  input  logic              i_commit,
  input  logic              i_mode,
  input  logic              i_mute,
  output logic              o_dac
);

  // Two's complement -> offset binary is a flip of the sign bit.
  localparam logic [DATA_W-1:0] MSB_FLIP = {(SIGNED_IN != 0), {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] r_pending;
  logic              r_pend_flag;
  logic [DATA_W-1:0] r_active;
  logic [DATA_W:0]   r_acc;
  logic [DATA_W-1:0] r_pwm_cnt;
  logic              r_mode_q;
  logic              r_dac;

  logic [DATA_W-1:0] w_smp_in;
  logic              w_mode_chg;
  logic [DATA_W:0]   w_acc_nxt;
  logic [DATA_W-1:0] w_pwm_nxt;
  logic              w_dac_nxt;

  assign w_smp_in   = i_smp_data ^ MSB_FLIP;
  assign w_mode_chg = (i_mode != r_mode_q);

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_acc_nxt = r_acc;
    w_pwm_nxt = r_pwm_cnt;
    w_dac_nxt = 1'b0;
    if (i_mute || w_mode_chg) begin
      // Restart from a clean state so the new mode/unmute begins at phase 0.
      w_acc_nxt = '0;
      w_pwm_nxt = '0;
    end else if (i_mode == MODE_SD) begin
      // Carry out of the low DATA_W bits is the output bit; when gated off
      // only the carry is dropped and the residue is kept for the next pass.
      if (i_vol_en) begin
        w_acc_nxt = {1'b0, r_acc[DATA_W-1:0]} + {1'b0, r_active};
      end else begin
        w_acc_nxt = {1'b0, r_acc[DATA_W-1:0]};
      end
      w_dac_nxt = w_acc_nxt[DATA_W];
    end else begin
      if (i_vol_en) begin
        w_pwm_nxt = r_pwm_cnt + 1'b1;
      end
      w_dac_nxt = i_vol_en & (r_pwm_cnt < r_active);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk32) begin
    if (rst) begin
      r_pending   <= '0;
      r_pend_flag <= 1'b0;
      r_active    <= '0;
      r_acc       <= '0;
      r_pwm_cnt   <= '0;
      r_dac       <= 1'b0;
      r_mode_q    <= i_mode;  // no spurious mode change on release
    end else begin
      r_mode_q  <= i_mode;
      r_acc     <= w_acc_nxt;
      r_pwm_cnt <= w_pwm_nxt;
      r_dac     <= w_dac_nxt;
      if (i_commit && r_pend_flag) begin
        r_active    <= r_pending;
        r_pend_flag <= 1'b0;
      end
      // A write on the commit cycle is placed after the commit: the commit
      // takes the old pending value and this write waits a whole frame.
      if (i_smp_wr) begin
        r_pending   <= w_smp_in;
        r_pend_flag <= 1'b1;
      end
    end
  end

  assign o_dac = r_dac;

endmodule

// File: rtl/gs_dac_multi.sv
// N-channel volume-gated 1-bit DAC (General Sound successor).
//   clk32 : system clock, rising edge
//   rst   : synchronous reset, active-high
//   bus   : gs_dac_multi_if slave modport (sample/volume writes, mode,
//           mute, dac_out, frame_tick)
// Holds the volume counter, the per-channel volume registers, write
// decode and frame_tick; per-channel datapath lives in gs_dac_channel.
module gs_dac_multi
  import gs_dac_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int DATA_W    = 8,
  parameter int VOL_W     = 6,
  parameter int VOL_STEP  = 31,
  parameter int SIGNED_IN = 0
) (
  input  logic           clk32,
  input  logic           rst,
  gs_dac_multi_if.slave  bus
);

  localparam int               CH_W = ch_width(CHANNELS);
  localparam logic [VOL_W-1:0] STEP = VOL_W'(VOL_STEP);

  logic [VOL_W-1:0]    r_vol_cnt;
  logic [VOL_W-1:0]    r_vol [CHANNELS];
  logic [CHANNELS-1:0] r_vol_en;
  logic                r_frame_tick;

  logic [VOL_W-1:0]    w_vol_cnt_nxt;
  logic                w_commit;
  logic [CHANNELS-1:0] w_smp_wr;
  logic [CHANNELS-1:0] w_dac;

  assign w_vol_cnt_nxt = r_vol_cnt + STEP;

  // frame_tick is registered so it is high exactly while vol_cnt == 0; the
  // vol_cnt == 0 right after reset release has no tick, so the first commit
  // lands one full frame later.
  assign w_commit = r_frame_tick;

  always_ff @(posedge clk32) begin
    if (rst) begin
      r_vol_cnt    <= '0;
      r_frame_tick <= 1'b0;
      r_vol_en     <= '0;
      // NOTE: the volume array is a handful of flops, not a RAM, so it is
      // cleared on reset like any other register.
      for (int i = 0; i < CHANNELS; i++) begin
        r_vol[i] <= '0;
      end
    end else begin
      r_vol_cnt    <= w_vol_cnt_nxt;
      r_frame_tick <= (w_vol_cnt_nxt == '0);
      for (int i = 0; i < CHANNELS; i++) begin
        r_vol_en[i] <= (r_vol_cnt < r_vol[i]);
        // Indices with no matching channel simply never match.
        if (bus.vol_wr && (bus.vol_ch == CH_W'(i))) begin
          r_vol[i] <= bus.vol_data;
        end
      end
    end
  end

  always_comb begin
    w_smp_wr = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_smp_wr[i] = bus.smp_wr && (bus.smp_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    gs_dac_channel #(
      .DATA_W    (DATA_W),
      .SIGNED_IN (SIGNED_IN)
    ) u_ch (
      .clk32      (clk32),
      .rst        (rst),
      .i_smp_wr   (w_smp_wr[g]),
      .i_smp_data (bus.smp_data),
      .i_vol_en   (r_vol_en[g]),
      .i_commit   (w_commit),
      .i_mode     (bus.mode[g]),
      .i_mute     (bus.mute),
      .o_dac      (w_dac[g])
    );
  end

  assign bus.dac_out    = w_dac;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_gs_dac_multi.sv
// Directed bench for gs_dac_multi: DUT1 is the default 4-channel build,
// DUT2 a 3-channel build with signed input.
module tb_gs_dac_multi;

  logic clk32;
  logic rst;

  int n_cmp = 0;
  int n_err = 0;

  gs_dac_multi_if #(.CHANNELS(4), .DATA_W(8), .VOL_W(6)) bus1 ();
  gs_dac_multi_if #(.CHANNELS(3), .DATA_W(8), .VOL_W(6)) bus2 ();

  gs_dac_multi #(
    .CHANNELS(4), .DATA_W(8), .VOL_W(6), .VOL_STEP(31), .SIGNED_IN(0)
  ) u_dut1 (
    .clk32 (clk32),
    .rst   (rst),
    .bus   (bus1)
  );

  gs_dac_multi #(
    .CHANNELS(3), .DATA_W(8), .VOL_W(6), .VOL_STEP(31), .SIGNED_IN(1)
  ) u_dut2 (
    .clk32 (clk32),
    .rst   (rst),
    .bus   (bus2)
  );

  initial clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout required summary before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic logic dac_bit(input bit sel, input int ch);
    return sel ? bus2.dac_out[ch] : bus1.dac_out[ch];
  endfunction

  function automatic logic tick_bit(input bit sel);
    return sel ? bus2.frame_tick : bus1.frame_tick;
  endfunction

  task automatic idle_inputs();
    bus1.smp_wr = 1'b0; bus1.smp_ch = '0; bus1.smp_data = '0;
    bus1.vol_wr = 1'b0; bus1.vol_ch = '0; bus1.vol_data = '0;
    bus2.smp_wr = 1'b0; bus2.smp_ch = '0; bus2.smp_data = '0;
    bus2.vol_wr = 1'b0; bus2.vol_ch = '0; bus2.vol_data = '0;
  endtask

  // Leaves rst low at a negedge; the next posedge is the first live edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    idle_inputs();
    repeat (4) @(negedge clk32);
    check({tag, "_dac1"}, 32'(bus1.dac_out), 32'd0);
    check({tag, "_tick1"}, 32'(bus1.frame_tick), 32'd0);
    check({tag, "_dac2"}, 32'(bus2.dac_out), 32'd0);
    rst = 1'b0;
  endtask

  task automatic vol_write(input bit sel, input int ch, input int val);
    if (sel) begin
      bus2.vol_wr = 1'b1; bus2.vol_ch = 2'(ch); bus2.vol_data = 6'(val);
    end else begin
      bus1.vol_wr = 1'b1; bus1.vol_ch = 2'(ch); bus1.vol_data = 6'(val);
    end
    @(negedge clk32);
    bus1.vol_wr = 1'b0;
    bus2.vol_wr = 1'b0;
  endtask

  task automatic smp_write(input bit sel, input int ch, input int val);
    if (sel) begin
      bus2.smp_wr = 1'b1; bus2.smp_ch = 2'(ch); bus2.smp_data = 8'(val);
    end else begin
      bus1.smp_wr = 1'b1; bus1.smp_ch = 2'(ch); bus1.smp_data = 8'(val);
    end
    @(negedge clk32);
    bus1.smp_wr = 1'b0;
    bus2.smp_wr = 1'b0;
  endtask

  task automatic count_ones(input bit sel, input int ch, input int cycles, output int ones);
    ones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk32);
      if (dac_bit(sel, ch) === 1'b1) ones++;
    end
  endtask

  // Returns at the negedge where frame_tick is seen; counts ones on ch meanwhile.
  task automatic wait_tick(input bit sel, input int ch, input string tag,
                           output int n, output int ones);
    n = 0;
    ones = 0;
    do begin
      @(negedge clk32);
      n++;
      if (dac_bit(sel, ch) === 1'b1) ones++;
    end while (tick_bit(sel) !== 1'b1 && n < 200);
    check(tag, 32'(tick_bit(sel)), 32'd1);
  endtask

  initial begin
    int n;
    int ones;
    rst = 1'b1;
    bus1.mode = '0; bus1.mute = 1'b0;
    bus2.mode = '0; bus2.mute = 1'b0;
    idle_inputs();

    // 1: sigma-delta, vol 63, sample 0x80 -> half of the 63/64 enabled cycles
    do_reset("rst0");
    vol_write(0, 0, 63);
    smp_write(0, 0, 8'h80);
    wait_tick(0, 0, "t1_tick", n, ones);
    count_ones(0, 0, 4096, ones);
    check_range("t1_sd_density", ones, 2014, 2018);

    // 2: PWM, sample 0x40; 52 extra cycles put the counter at 112 when the
    // window opens, so the window holds exactly 1008 counts below 0x40.
    bus1.mode = 4'b0001;
    do_reset("rst2");
    vol_write(0, 0, 63);
    smp_write(0, 0, 8'h40);
    wait_tick(0, 0, "t2_tick", n, ones);
    repeat (52) @(negedge clk32);
    count_ones(0, 0, 4096, ones);
    check_range("t2_pwm_density", ones, 1004, 1012);
    vol_write(0, 0, 0);
    repeat (2) @(negedge clk32);
    count_ones(0, 0, 512, ones);
    check("t2_vol0_silent", 32'(ones), 32'd0);

    // 3a: write on the commit cycle waits one full frame
    bus1.mode = 4'b0000;
    do_reset("rst3");
    vol_write(0, 1, 63);
    vol_write(0, 2, 63);
    wait_tick(0, 1, "t3_tick0", n, ones);
    smp_write(0, 1, 8'hFF);
    count_ones(0, 1, 64, ones);
    check("t3_tickwr_held", 32'(ones), 32'd0);
    count_ones(0, 1, 64, ones);
    check_range("t3_tickwr_late", ones, 56, 64);

    // 3b: mid-frame write (vol_cnt == 5) stays pending until the next tick
    repeat (26) @(negedge clk32);
    smp_write(0, 2, 8'hFF);
    wait_tick(0, 2, "t3_tick1", n, ones);
    check("t3_midwr_held", 32'(ones), 32'd0);
    check_range("t3_tick_within_frame", n, 1, 64);
    count_ones(0, 2, 64, ones);
    check_range("t3_midwr_commit", ones, 56, 64);

    // mode change blanks the output for one cycle, then PWM at 0xFF
    bus1.mode = 4'b0100;
    @(negedge clk32);
    check("t3_mode_chg_blank", 32'(bus1.dac_out[2]), 32'd0);
    count_ones(0, 2, 64, ones);
    check_range("t3_pwm_ff", ones, 56, 64);

    // 4: out-of-range indices and signed input on the 3-channel build
    do_reset("rst4");
    vol_write(1, 0, 63);
    vol_write(1, 1, 63);
    vol_write(1, 2, 63);
    vol_write(1, 3, 0);
    smp_write(1, 3, 8'hFF);
    wait_tick(1, 0, "t4_tick0", n, ones);
    n = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk32);
      if (bus2.dac_out !== 3'b000) n++;
    end
    check("t4_oob_no_effect", 32'(n), 32'd0);
    smp_write(1, 0, 8'h00);
    wait_tick(1, 0, "t4_tick1", n, ones);
    count_ones(1, 0, 4096, ones);
    check_range("t4_signed_0x00", ones, 2014, 2018);

    // 5: mute, with commits and writes continuing underneath
    do_reset("rst5");
    vol_write(0, 0, 63);
    smp_write(0, 0, 8'h80);
    wait_tick(0, 0, "t5_tick", n, ones);
    count_ones(0, 0, 256, ones);
    check_range("t5_premute", ones, 122, 130);
    bus1.mute = 1'b1;
    @(negedge clk32);
    check("t5_mute_fast", 32'(bus1.dac_out), 32'd0);
    vol_write(0, 1, 63);
    smp_write(0, 1, 8'h80);
    count_ones(0, 0, 256, ones);
    check("t5_mute_ch0", 32'(ones), 32'd0);
    count_ones(0, 1, 128, ones);
    check("t5_mute_ch1", 32'(ones), 32'd0);
    bus1.mute = 1'b0;
    count_ones(0, 1, 64, ones);
    check_range("t5_ch1_commit_in_mute", ones, 29, 33);
    count_ones(0, 0, 4096, ones);
    check_range("t5_unmute_density", ones, 2014, 2018);

    // 6: reset mid-frame drops pending data; first tick a full frame later
    smp_write(0, 0, 8'hFF);
    rst = 1'b1;
    @(negedge clk32);
    check("t6_rst_dac", 32'(bus1.dac_out), 32'd0);
    check("t6_rst_tick", 32'(bus1.frame_tick), 32'd0);
    repeat (2) @(negedge clk32);
    rst = 1'b0;
    bus1.vol_wr = 1'b1; bus1.vol_ch = 2'd0; bus1.vol_data = 6'd63;
    n = 0;
    do begin
      @(negedge clk32);
      bus1.vol_wr = 1'b0;
      n++;
    end while (bus1.frame_tick !== 1'b1 && n < 200);
    check("t6_first_tick_cycle", 32'(n), 32'd64);
    count_ones(0, 0, 256, ones);
    check("t6_pending_dropped", 32'(ones), 32'd0);
    count_ones(0, 1, 256, ones);
    check("t6_active_cleared", 32'(ones), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
